inst_prefetch_queue: RTL and testbench

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

---
 rtl/inst_prefetch_queue_pkg.sv | 24 ++
 rtl/ipq_fifo.sv | 64 ++++++
 rtl/inst_prefetch_queue.sv | 171 +++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// rtl/inst_prefetch_queue_pkg.sv - shared types and widths for the instruction prefetch queue
package inst_prefetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // REQ: request driven, WAIT: one fetch outstanding, DRAIN: stale response expected, HOLD: queue full
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } ipq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ipq_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ipq_fifo.sv
// rtl/ipq_fifo.sv - circular {pc, inst} entry buffer with single-cycle flush
module ipq_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  ipq_entry_t             i_push_entry,
  input  logic                   i_pop,
  output ipq_entry_t             o_head,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  ipq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // The producer reserves a slot before fetching, so a push into a full buffer is simply refused.
  assign w_push_ok = i_push && (r_count != FULL_CNT);
  assign w_pop_ok  = i_pop && (r_count != '0);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage write; no reset needed because count gates visibility of every slot.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointers and occupancy; flush empties the buffer in one cycle, pointers wrap at DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - instruction prefetch queue top; PREFETCH_STATS_EN adds flush/hold counters
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int                DEPTH   = 4,
  parameter logic [ADDR_W-1:0] INIT_PC = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_req_valid,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  input  logic              i_mem_req_ready,
  input  logic              i_mem_rsp_valid,
  input  logic [INST_W-1:0] i_mem_rsp_data,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst_data,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]       o_flush_count,
  output logic [15:0]       o_hold_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ipq_state_e        r_state;
  ipq_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_req_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_head_vis;
  logic              w_empty;
  logic              w_has_room;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_after;
  ipq_entry_t        w_head;
  ipq_entry_t        w_push_entry;

  assign w_redirect_pc = word_align(i_redirect_pc);

  // Outputs are held low while reset is asserted, independent of register contents.
  assign o_mem_req_valid = i_rst_n && (r_state == ST_REQ);
  assign o_mem_req_addr  = r_fetch_pc;
  assign w_req_fire      = o_mem_req_valid && i_mem_req_ready;

  assign w_head_vis   = i_rst_n && !w_empty;
  assign o_inst_valid = w_head_vis && !i_redirect_valid;
  assign o_inst_data  = w_head_vis ? w_head.inst : '0;
  assign o_inst_pc    = w_head_vis ? w_head.pc : '0;

  // A pop during a redirect cannot happen since inst_valid is already masked; a response that
  // coincides with a redirect belongs to the old path and is dropped.
  assign w_pop  = o_inst_valid && i_inst_ready;
  assign w_push = (r_state == ST_WAIT) && i_mem_rsp_valid && !i_redirect_valid;

  assign w_push_entry.pc   = r_pend_pc;
  assign w_push_entry.inst = i_mem_rsp_data;

  // Occupancy as it will be after this edge; decides whether another fetch slot is free.
  assign w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_has_room    = (w_count_after != FULL_CNT);

  ipq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect_valid),
    .i_push      (w_push),
    .i_push_entry(w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Fetch FSM next state and next fetch address; redirect always takes priority.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      ST_REQ: begin
        if (i_redirect_valid) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = w_req_fire ? ST_DRAIN : ST_REQ;
        end else if (w_req_fire) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_redirect_valid) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = i_mem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (i_mem_rsp_valid) begin
          w_state_nxt = w_has_room ? ST_REQ : ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The stale response still has to be swallowed; a new redirect only moves the target.
        if (i_redirect_valid) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end
        if (i_mem_rsp_valid) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (i_redirect_valid) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = ST_REQ;
        end else if (w_has_room) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // FSM state, fetch address and the address of the request in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_REQ;
      r_fetch_pc <= word_align(INIT_PC);
      r_pend_pc  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_req_fire) begin
        r_pend_pc <= r_fetch_pc;
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_flush_count;
  logic [15:0] r_hold_count;

  // Saturating counts of redirect cycles and cycles spent waiting for queue space.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_flush_count <= '0;
      r_hold_count  <= '0;
    end else begin
      if (i_redirect_valid && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
      if ((r_state == ST_HOLD) && (r_hold_count != 16'hFFFF)) begin
        r_hold_count <= r_hold_count + 16'd1;
      end
    end
  end

  assign o_flush_count = r_flush_count;
  assign o_hold_count  = r_hold_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - self-checking bench for inst_prefetch_queue (optional PREFETCH_STATS_EN)
module tb_inst_prefetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] INIT_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef PREFETCH_STATS_EN
  logic [15:0] flush_count;
  logic [15:0] hold_count;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  inst_prefetch_queue #(
    .DEPTH  (DEPTH),
    .INIT_PC(INIT_PC)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_mem_req_valid (req_valid),
    .o_mem_req_addr  (req_addr),
    .i_mem_req_ready (ready),
    .i_mem_rsp_valid (rsp_valid),
    .i_mem_rsp_data  (rsp_data),
    .i_redirect_valid(redirect),
    .i_redirect_pc   (rpc),
    .o_inst_valid    (inst_valid),
    .o_inst_data     (inst_data),
    .o_inst_pc       (inst_pc),
    .i_inst_ready    (inst_ready)
`ifdef PREFETCH_STATS_EN
    ,
    .o_flush_count   (flush_count),
    .o_hold_count    (hold_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    ready = 0; rsp_valid = 0; rsp_data = 0; redirect = 0; rpc = 0; inst_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    go();
    go();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    go();
    go();
    mid();
    n_vec++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_vec++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_inst_data: got %h want 0", inst_data); end
    n_vec++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    go();
    rst_n = 1;
    mid();
    n_vec++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_valid: got %b want 1", req_valid); end
    n_vec++; if (req_addr !== INIT_PC) begin n_fail++; $display("FAIL post_rst_req_addr: got %h want %h", req_addr, INIT_PC); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    ready = 1;
    mid();
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_fail++; $display("FAIL ff_req: got %b/%h want 1/0", req_valid, req_addr); end
    go();
    ready = 0; rsp_valid = 1; rsp_data = 32'h0000_0001;
    mid();
    n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ff_early_valid: got %b want 0", inst_valid); end
    go();
    rsp_valid = 0;
    mid();
    n_vec++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL ff_inst_valid: got %b want 1", inst_valid); end
    n_vec++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL ff_inst_pc: got %h want 0", inst_pc); end
    n_vec++; if (inst_data !== 32'h1) begin n_fail++; $display("FAIL ff_inst_data: got %h want 1", inst_data); end
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'h4) begin n_fail++; $display("FAIL ff_next_req: got %b/%h want 1/4", req_valid, req_addr); end
    go();
  endtask

  task automatic test_fill_hold();
    int  n_acc;
    bit  pend;
    bit  hs;
    do_reset();
    ready = 1; inst_ready = 0; n_acc = 0; pend = 0;
    for (int c = 0; c < 24; c++) begin
      rsp_valid = pend; rsp_data = 32'hC0DE_0000 + c;
      mid();
      hs = req_valid && ready;
      if (hs) begin
        n_vec++; if (req_addr !== 32'(n_acc * 4)) begin n_fail++; $display("FAIL fill_addr%0d: got %h want %h", n_acc, req_addr, 32'(n_acc * 4)); end
        n_acc++;
      end
      pend = hs;
      go();
    end
    rsp_valid = 0;
    n_vec++; if (n_acc != DEPTH) begin n_fail++; $display("FAIL fill_accepted: got %0d want %0d", n_acc, DEPTH); end
    mid();
    n_vec++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_req_valid: got %b want 0", req_valid); end
    go();
    inst_ready = 1;
    mid();
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL hold_head: got %b/%h want 1/0", inst_valid, inst_pc); end
    go();
    inst_ready = 0;
    mid();
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin n_fail++; $display("FAIL hold_resume: got %b/%h want 1/10", req_valid, req_addr); end
    go();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ready = 1;
    go();
    ready = 0; redirect = 1; rpc = 32'h100;
    mid();
    n_vec++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_wait_req: got %b want 0", req_valid); end
    go();
    redirect = 0; rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
    mid();
    n_vec++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drain_req: got %b want 0", req_valid); end
    go();
    rsp_valid = 0;
    mid();
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin n_fail++; $display("FAIL rw_new_req: got %b/%h want 1/100", req_valid, req_addr); end
    n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale_inst: got %b pc %h want 0", inst_valid, inst_pc); end
    go();
    ready = 1;
    go();
    ready = 0; rsp_valid = 1; rsp_data = 32'h0000_1234;
    go();
    rsp_valid = 0;
    mid();
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h1234) begin
      n_fail++; $display("FAIL rw_first_inst: got %b/%h/%h want 1/100/1234", inst_valid, inst_pc, inst_data); end
    go();
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    ready = 1;
    go();
    ready = 0; rsp_valid = 1; rsp_data = 32'hAA;
    go();
    rsp_valid = 0; ready = 1;
    go();
    ready = 0; redirect = 1; rpc = 32'h200; rsp_valid = 1; rsp_data = 32'hBB; inst_ready = 1;
    mid();
    n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_forced_invalid: got %b want 0", inst_valid); end
    go();
    idle();
    mid();
    n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_queue_empty: got %b pc %h want 0", inst_valid, inst_pc); end
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin n_fail++; $display("FAIL rr_req: got %b/%h want 1/200", req_valid, req_addr); end
    go();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1; rpc = 32'hFFFF_FFFC;
    go();
    redirect = 0; ready = 1;
    mid();
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %b/%h want 1/fffffffc", req_valid, req_addr); end
    go();
    ready = 0; rsp_valid = 1; rsp_data = 32'h5555;
    go();
    rsp_valid = 0;
    mid();
    n_vec++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_req1: got %b/%h want 1/0", req_valid, req_addr); end
    n_vec++; if (inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_inst_pc: got %h want fffffffc", inst_pc); end
    go();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1;
    go();
    ready = 0; rst_n = 0;
    mid();
    n_vec++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_in_reset: got %b want 0", req_valid); end
    go();
    rst_n = 1; rsp_valid = 1; rsp_data = 32'h0BAD;
    mid();
    n_vec++; if (req_valid !== 1'b1 || req_addr !== INIT_PC) begin n_fail++; $display("FAIL rm_req: got %b/%h want 1/%h", req_valid, req_addr, INIT_PC); end
    go();
    rsp_valid = 0;
    mid();
    n_vec++; if (inst_valid !== 1'b0 || req_valid !== 1'b1) begin n_fail++; $display("FAIL rm_late_rsp: got iv %b rv %b want 0/1", inst_valid, req_valid); end
    go();
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic [31:0] nxt_pc;
    logic [31:0] out_pc;
    bit          busy, stale, mem_pend, exp_rv, exp_iv, hs, rsp, pop;
    int          mem_lat;
    do_reset();
    nxt_pc = INIT_PC; out_pc = 0; busy = 0; stale = 0; mem_pend = 0; mem_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect   = ($urandom_range(0, 19) == 0);
      rpc        = $urandom;
      ready      = 1'($urandom_range(0, 1));
      inst_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      rsp_data   = $urandom;
      if (mem_pend && mem_lat == 1) rsp_valid = 1;
      else if (!mem_pend && $urandom_range(0, 15) == 0) rsp_valid = 1;
      else rsp_valid = 0;
      mid();
      exp_rv = !busy && (q.size() < DEPTH);
      exp_iv = (q.size() > 0) && !redirect;
      n_vec++; if (req_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_req_valid c%0d: got %b want %b", c, req_valid, exp_rv); end
      n_vec++; if (inst_valid !== exp_iv) begin n_fail++; $display("FAIL rnd_inst_valid c%0d: got %b want %b", c, inst_valid, exp_iv); end
      if (exp_rv) begin
        n_vec++; if (req_addr !== nxt_pc) begin n_fail++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, req_addr, nxt_pc); end
      end
      if (exp_iv) begin
        n_vec++; if (inst_pc !== q[0].pc || inst_data !== q[0].inst) begin
          n_fail++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, inst_pc, inst_data, q[0].pc, q[0].inst); end
      end
      hs  = exp_rv && ready;
      rsp = rsp_valid && busy;
      pop = exp_iv && inst_ready;
      if (redirect) begin
        q.delete();
        nxt_pc = {rpc[31:2], 2'b00};
        if (hs) begin busy = 1; stale = 1; end
        else if (rsp) busy = 0;
        else if (busy) stale = 1;
      end else begin
        if (pop) void'(q.pop_front());
        if (rsp) begin
          if (!stale) q.push_back('{pc: out_pc, inst: rsp_data});
          busy = 0;
        end
        if (hs) begin busy = 1; stale = 0; out_pc = nxt_pc; nxt_pc = nxt_pc + 32'd4; end
      end
      if (mem_pend) begin
        if (mem_lat == 1) mem_pend = 0;
        else mem_lat--;
      end
      if (req_valid && ready) begin mem_pend = 1; mem_lat = $urandom_range(1, 3); end
      go();
    end
    idle();
  endtask

`ifdef PREFETCH_STATS_EN
  task automatic test_stats();
    do_reset();
    redirect = 1; rpc = 32'h40;
    go();
    go();
    go();
    redirect = 0;
    mid();
    n_vec++; if (flush_count !== 16'd3) begin n_fail++; $display("FAIL stats_flush: got %0d want 3", flush_count); end
    n_vec++; if (hold_count !== 16'd0) begin n_fail++; $display("FAIL stats_hold: got %0d want 0", hold_count); end
    go();
    rst_n = 0;
    go();
    rst_n = 1;
    mid();
    n_vec++; if (flush_count !== 16'd0 || hold_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d/%0d want 0/0", flush_count, hold_count); end
    n_vec++; if (req_addr !== INIT_PC) begin n_fail++; $display("FAIL stats_reset_addr: got %h want %h", req_addr, INIT_PC); end
    go();
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_fill_hold();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef PREFETCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
